// File: rtl/dmem_bus_ctrl_if.sv
// +----------------------------------------------------------------------+
// | dmem_bus_ctrl_if : req/ack data-memory bus between core and memory  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface dmem_bus_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [DATA_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
// +----------------------------------------------------------------------+
// | dmem_bus_ctrl : MEM-stage load/store to variable-latency bus bridge  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              memread,
  input  wire logic              memwrite,
  input  wire logic [DATA_W-1:0] alu_result,
  input  wire logic [DATA_W-1:0] rdata2out,
  dmem_bus_ctrl_if.master        bus,
  output logic                   stall,
  output logic [DATA_W-1:0]      read_data,
  output logic                   rd_valid,
  output logic                   access_err,
  output logic [1:0]             err_code
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
  localparam logic [1:0] c_code_conflict = 2'b00;
  localparam logic [1:0] c_code_misalign = 2'b01;
  localparam logic [1:0] c_code_bus_err  = 2'b10;
  localparam logic [1:0] c_code_timeout  = 2'b11;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [DATA_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_read_data;
  logic              r_rd_valid;
  logic              r_access_err;
  logic [1:0]        r_err_code;

  logic w_req;
  logic w_conflict;
  logic w_misaligned;
  logic w_reject;
  logic w_start;

  assign w_req        = memread | memwrite;
  assign w_conflict   = memread & memwrite;
  assign w_misaligned = |alu_result[1:0];
  assign w_reject     = w_req & (w_conflict | w_misaligned);
  assign w_start      = w_req & ~w_reject;

  // Stall is raised in the accepting IDLE cycle itself so EX/MEM holds the request.
  assign stall = rst_n & ((r_state == ST_REQ) | ((r_state == ST_IDLE) & w_start));

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign read_data     = r_read_data;
  assign rd_valid      = r_rd_valid;
  assign access_err    = r_access_err;
  assign err_code      = r_err_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_read_data  <= '0;
      r_rd_valid   <= 1'b0;
      r_access_err <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_rd_valid   <= 1'b0;
      r_access_err <= 1'b0;
      r_err_code   <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_reject) begin
            r_access_err <= 1'b1;
            r_err_code   <= w_conflict ? c_code_conflict : c_code_misalign;
          end else if (w_start) begin
            r_bus_addr  <= alu_result;
            r_bus_wdata <= rdata2out;
            r_bus_we    <= memwrite;
            r_cnt       <= 8'd0;
            r_bus_req   <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack in the last allowed cycle beats the timeout.
          if (bus.bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_DONE;
            if (bus.bus_err) begin
              r_access_err <= 1'b1;
              r_err_code   <= c_code_bus_err;
            end else if (!r_bus_we) begin
              r_read_data <= bus.bus_rdata;
              r_rd_valid  <= 1'b1;
            end
          end else if (r_cnt == c_timeout_last) begin
            r_bus_req    <= 1'b0;
            r_access_err <= 1'b1;
            r_err_code   <= c_code_timeout;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_bus_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_dmem_bus_ctrl : directed self-checking bench for dmem_bus_ctrl    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        memread;
  logic        memwrite;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic        stall;
  logic [31:0] read_data;
  logic        rd_valid;
  logic        access_err;
  logic [1:0]  err_code;

  int n_checks;
  int n_fail;

  dmem_bus_ctrl_if #(.DATA_W(32)) bus_if ();

  dmem_bus_ctrl #(
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memread    (memread),
    .memwrite   (memwrite),
    .alu_result (alu_result),
    .rdata2out  (rdata2out),
    .bus        (bus_if),
    .stall      (stall),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .access_err (access_err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; memread = 1'b1; memwrite = 1'b0;
    alu_result = 32'h10; rdata2out = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'h0;

    // Reset with a pending read
    tick(); tick();
    check_val("rst_stall",    32'(stall), 32'd0);
    check_val("rst_bus_req",  32'(bus_if.bus_req), 32'd0);
    check_val("rst_bus_we",   32'(bus_if.bus_we), 32'd0);
    check_val("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check_val("rst_rdata",    read_data, 32'h0);
    check_val("rst_pulses",   {29'd0, rd_valid, access_err, 1'b0} | 32'(err_code), 32'd0);

    // Aligned load, ack in first REQ cycle
    rst_n = 1'b1;
    #1;
    check_val("ld_idle_stall", 32'(stall), 32'd1);
    tick();
    check_val("ld_req",       32'(bus_if.bus_req), 32'd1);
    check_val("ld_addr",      bus_if.bus_addr, 32'h10);
    check_val("ld_we",        32'(bus_if.bus_we), 32'd0);
    check_val("ld_req_stall", 32'(stall), 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_if.bus_ack = 1'b0; memread = 1'b0;
    #1;
    check_val("ld_done_stall", 32'(stall), 32'd0);
    check_val("ld_rd_valid",   32'(rd_valid), 32'd1);
    check_val("ld_read_data",  read_data, 32'hDEAD_BEEF);
    check_val("ld_done_req",   32'(bus_if.bus_req), 32'd0);
    tick();
    check_val("ld_rd_valid_clr", 32'(rd_valid), 32'd0);

    // Store with 3 wait states; inputs change mid-REQ to prove latching
    memwrite = 1'b1; alu_result = 32'h24; rdata2out = 32'h1234_5678;
    #1;
    check_val("st_idle_stall", 32'(stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      alu_result = 32'hFFFF_FFF0; rdata2out = 32'hA5A5_A5A5;
      check_val($sformatf("st_req%0d", i),   32'(bus_if.bus_req), 32'd1);
      check_val($sformatf("st_we%0d", i),    32'(bus_if.bus_we), 32'd1);
      check_val($sformatf("st_wdata%0d", i), bus_if.bus_wdata, 32'h1234_5678);
      check_val($sformatf("st_addr%0d", i),  bus_if.bus_addr, 32'h24);
      check_val($sformatf("st_stall%0d", i), 32'(stall), 32'd1);
      if (i == 4) bus_if.bus_ack = 1'b1;
    end
    tick();
    bus_if.bus_ack = 1'b0; memwrite = 1'b0;
    #1;
    check_val("st_done_stall", 32'(stall), 32'd0);
    check_val("st_no_rdvalid", 32'(rd_valid), 32'd0);
    check_val("st_no_err",     32'(access_err), 32'd0);
    check_val("st_keep_rdata", read_data, 32'hDEAD_BEEF);
    tick();

    // Misaligned then conflict, back to back
    memread = 1'b1; alu_result = 32'h13;
    #1;
    check_val("mis_stall", 32'(stall), 32'd0);
    tick();
    memwrite = 1'b1; alu_result = 32'h20;
    #1;
    check_val("mis_err",   32'(access_err), 32'd1);
    check_val("mis_code",  32'(err_code), 32'd1);
    check_val("mis_req",   32'(bus_if.bus_req), 32'd0);
    check_val("cf_stall",  32'(stall), 32'd0);
    tick();
    memread = 1'b0; memwrite = 1'b0;
    #1;
    check_val("cf_err",  32'(access_err), 32'd1);
    check_val("cf_code", 32'(err_code), 32'd0);
    check_val("cf_req",  32'(bus_if.bus_req), 32'd0);
    tick();
    check_val("cf_err_clr", 32'(access_err), 32'd0);

    // Timeout: no ack ever
    memread = 1'b1; alu_result = 32'h30;
    tick();
    n = 0;
    while (bus_if.bus_req && n < 40) begin
      n++;
      tick();
    end
    memread = 1'b0;
    #1;
    check_val("to_req_cycles", 32'(n), 32'd15);
    check_val("to_err",   32'(access_err), 32'd1);
    check_val("to_code",  32'(err_code), 32'd3);
    check_val("to_rdata", read_data, 32'hDEAD_BEEF);
    check_val("to_stall", 32'(stall), 32'd0);
    tick();

    // Ack coincides with the last allowed REQ cycle: ack wins
    memread = 1'b1; alu_result = 32'h44;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check_val("ackto_req15", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_if.bus_ack = 1'b0; alu_result = 32'h48;
    #1;
    check_val("ackto_rdvalid", 32'(rd_valid), 32'd1);
    check_val("ackto_noerr",   32'(access_err), 32'd0);
    check_val("ackto_rdata",   read_data, 32'hCAFE_F00D);
    check_val("ackto_stall",   32'(stall), 32'd0);

    // Back-to-back read ending in a bus error
    tick();
    check_val("b2b_idle_stall", 32'(stall), 32'd1);
    tick();
    check_val("b2b_req",  32'(bus_if.bus_req), 32'd1);
    check_val("b2b_addr", bus_if.bus_addr, 32'h48);
    bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b1; bus_if.bus_rdata = 32'hFFFF_0000;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; memread = 1'b0;
    #1;
    check_val("be_err",     32'(access_err), 32'd1);
    check_val("be_code",    32'(err_code), 32'd2);
    check_val("be_rdata",   read_data, 32'hCAFE_F00D);
    check_val("be_rdvalid", 32'(rd_valid), 32'd0);
    tick();

    // Reset asserted in the second REQ cycle
    memread = 1'b1; alu_result = 32'h50;
    tick();
    tick();
    check_val("mr_req2", 32'(bus_if.bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mr_req_drop", 32'(bus_if.bus_req), 32'd0);
    check_val("mr_stall",    32'(stall), 32'd0);
    memread = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("mr_no_rdvalid", 32'(rd_valid), 32'd0);
    check_val("mr_no_err",     32'(access_err), 32'd0);
    tick();
    check_val("mr_no_rdvalid2", 32'(rd_valid), 32'd0);
    check_val("mr_rdata_rst",   read_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
